// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, wait-counter width and address error decode.
package dm_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam logic       ERR_NONE   = 1'b0;
   localparam logic       ERR_ADDR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Misaligned or beyond the populated word range; never aliased.
   function automatic logic addr_error(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] hi;
      hi = addr >> (aw + 2);
      return (((addr[1:0] & ALIGN_MASK) != 2'b00) || (hi != '0)) ? ERR_ADDR : ERR_NONE;
   endfunction

endpackage

// File: rtl/dm_array.sv
// Single-port word RAM with synchronous write and registered read port.
// Contents are never reset; only the read register is.
module dm_array
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic                  i_clr,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_W-1:0]     i_wdata,
   output logic [DATA_W-1:0]     o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register holds its word until the next read or clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end else if (i_clr) begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Load/store responder: accepts one word request, waits LATENCY cycles,
// commits to the RAM and pulses ready for one cycle.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic        ready,
   output logic [31:0] data_out,
   output logic        err,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
   localparam logic             ZERO_LAT = (LATENCY == 0);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [ADDR_WIDTH-1:0]   r_word;
   logic [31:0]             r_wdata;
   logic                    r_we;
   logic                    r_err_l;
   logic                    r_ready;
   logic                    r_err;
   logic                    r_busy;

   logic                    w_addr_err;
   logic                    w_accept;
   logic                    w_commit;
   logic                    w_sel_live;
   logic                    w_cur_we;
   logic                    w_cur_err;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic                    w_ram_clr;
   logic [ADDR_WIDTH-1:0]   w_ram_addr;
   logic [31:0]             w_ram_wdata;
   logic [31:0]             w_rdata;

   assign w_addr_err = addr_error(address, ADDR_WIDTH);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_state_nxt = ZERO_LAT ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // With zero latency the commit happens on the acceptance edge, so the
   // live request fields feed the RAM instead of the latched copies.
   always_comb begin
      w_accept   = 1'b0;
      w_commit   = 1'b0;
      w_sel_live = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_accept   = req;
            w_commit   = req & ZERO_LAT;
            w_sel_live = 1'b1;
         end
         ST_WAIT: w_commit = (r_cnt == '0);
         default: begin
            w_accept = 1'b0;
            w_commit = 1'b0;
         end
      endcase
      w_cur_we    = w_sel_live ? mem_write : r_we;
      w_cur_err   = w_sel_live ? w_addr_err : r_err_l;
      w_ram_addr  = w_sel_live ? address[ADDR_WIDTH+1:2] : r_word;
      w_ram_wdata = w_sel_live ? data_in : r_wdata;
      w_ram_we    = w_commit & w_cur_we & ~w_cur_err;
      w_ram_re    = w_commit & ~w_cur_we & ~w_cur_err;
      w_ram_clr   = w_commit & (w_cur_we | w_cur_err);
   end

   // Request latches, wait counter and registered response flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_word  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_err_l <= 1'b0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_word  <= address[ADDR_WIDTH+1:2];
            r_wdata <= data_in;
            r_we    <= mem_write;
            r_err_l <= w_addr_err;
            r_cnt   <= CNT_LOAD;
         end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         r_ready <= w_commit;
         r_err   <= w_commit & w_cur_err;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   dm_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_clr   (w_ram_clr),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_rdata)
   );

   assign ready    = r_ready;
   assign err      = r_err;
   assign busy     = r_busy;
   assign data_out = w_rdata;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (LATENCY 2 and 0) checked every cycle
// against a transaction-level model, plus directed scenario checks.
module tb_dm_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned BYTES = 4 << AW;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [1:0]        req_i;
   logic [1:0]        mw_i;
   logic [1:0][31:0]  addr_i;
   logic [1:0][31:0]  din_i;
   wire  [1:0]        rdy_o;
   wire  [1:0]        err_o;
   wire  [1:0]        busy_o;
   wire  [1:0][31:0]  dout_o;

   int vectors     = 0;
   int miscompares = 0;

   // model state, index 0 = LATENCY 2 instance, index 1 = LATENCY 0 instance
   int          lat_of [2] = '{2, 0};
   int          left   [2] = '{0, 0};
   logic [31:0] p_a    [2] = '{0, 0};
   logic [31:0] p_d    [2] = '{0, 0};
   bit          p_w    [2] = '{0, 0};
   bit          e_rdy  [2] = '{0, 0};
   bit          e_err  [2] = '{0, 0};
   bit          e_busy [2] = '{0, 0};
   logic [31:0] e_dout [2] = '{0, 0};
   logic [31:0] m_mem  [2][1024];

   dm_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u_l2 (
      .clock(clock), .reset(reset), .req(req_i[0]), .mem_write(mw_i[0]),
      .address(addr_i[0]), .data_in(din_i[0]), .ready(rdy_o[0]),
      .data_out(dout_o[0]), .err(err_o[0]), .busy(busy_o[0])
   );

   dm_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_l0 (
      .clock(clock), .reset(reset), .req(req_i[1]), .mem_write(mw_i[1]),
      .address(addr_i[1]), .data_in(din_i[1]), .ready(rdy_o[1]),
      .data_out(dout_o[1]), .err(err_o[1]), .busy(busy_o[1])
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      return 32'h5A5A_0000 | 32'(i);
   endfunction

   // Transaction model: a request occupies LATENCY+1 cycles, the last one
   // being the response; memory effects happen when the response is scheduled.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            left[k] = 0; e_rdy[k] = 0; e_err[k] = 0; e_busy[k] = 0; e_dout[k] = '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit bad;
            e_rdy[k] = 0;
            e_err[k] = 0;
            if (left[k] == 0) begin
               if (req_i[k]) begin
                  p_a[k] = addr_i[k]; p_d[k] = din_i[k]; p_w[k] = mw_i[k];
                  left[k] = lat_of[k] + 1;
               end
            end else begin
               left[k]--;
            end
            if (left[k] == 1) begin
               bad = ((p_a[k] % 4) != 0) || (p_a[k] >= BYTES);
               e_rdy[k] = 1;
               e_err[k] = bad;
               if (bad || p_w[k]) begin
                  if (p_w[k] && !bad) m_mem[k][p_a[k] / 4] = p_d[k];
                  e_dout[k] = '0;
               end else begin
                  e_dout[k] = m_mem[k][p_a[k] / 4];
               end
            end
            e_busy[k] = (left[k] != 0);
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   initial begin
      @(posedge reset);
      forever begin
         @(negedge clock);
         for (int k = 0; k < 2; k++) begin
            string nm;
            nm = (k == 0) ? "L2" : "L0";
            chk({nm, " ready"}, 32'(rdy_o[k]), 32'(e_rdy[k]));
            chk({nm, " err"}, 32'(err_o[k]), 32'(e_err[k]));
            chk({nm, " busy"}, 32'(busy_o[k]), 32'(e_busy[k]));
            chk({nm, " data_out"}, dout_o[k], e_dout[k]);
         end
      end
   end

   task automatic xfer(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input bit scr, output int cyc, output logic [31:0] dout, output logic e);
      bit done;
      done = 0; cyc = 0; dout = '0; e = 1'b0;
      @(negedge clock);
      req_i[k] = 1'b1; mw_i[k] = we; addr_i[k] = a; din_i[k] = d;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clock);
         if (n == 1 && scr) begin
            addr_i[k] = $urandom; din_i[k] = $urandom;
         end
         if (rdy_o[k]) begin
            done = 1; cyc = n; dout = dout_o[k]; e = err_o[k];
         end
      end
      req_i[k] = 1'b0; mw_i[k] = 1'b0; addr_i[k] = '0; din_i[k] = '0;
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL timeout: no ready on instance %0d got 0 expected 1", k);
      end
   endtask

   initial begin
      int          cyc;
      int          nr;
      logic [31:0] d;
      logic        e;
      req_i = '0; mw_i = '0; addr_i = '0; din_i = '0;
      #3 reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;

      @(negedge clock);
      chk("reset ready", 32'(rdy_o[0]), 32'd0);
      chk("reset busy", 32'(busy_o[0]), 32'd0);
      chk("reset err", 32'(err_o[0]), 32'd0);
      chk("reset data_out", dout_o[0], 32'd0);

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++)
            xfer(k, 1'b1, 32'(i * 4), init_val(i), 1'b0, cyc, d, e);

      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, cyc, d, e);
      chk("store latency", 32'(cyc), 32'd3);
      chk("store data_out", d, 32'd0);
      xfer(0, 1'b0, 32'h10, 32'd0, 1'b0, cyc, d, e);
      chk("load latency", 32'(cyc), 32'd3);
      chk("load data", d, 32'hDEAD_BEEF);
      chk("load err", 32'(e), 32'd0);

      xfer(0, 1'b0, 32'h6, 32'd0, 1'b0, cyc, d, e);
      chk("misalign err", 32'(e), 32'd1);
      chk("misalign data", d, 32'd0);
      xfer(0, 1'b0, 32'h4, 32'd0, 1'b0, cyc, d, e);
      chk("neighbour word", d, 32'h5A5A_0001);

      xfer(0, 1'b1, 32'h1000, 32'h0BAD_0BAD, 1'b0, cyc, d, e);
      chk("range err", 32'(e), 32'd1);
      xfer(0, 1'b0, 32'h0, 32'd0, 1'b0, cyc, d, e);
      chk("no alias", d, 32'h5A5A_0000);

      xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, cyc, d, e);
      chk("L0 latency", 32'(cyc), 32'd1);
      @(negedge clock);
      req_i[1] = 1'b1; mw_i[1] = 1'b0; addr_i[1] = 32'h10;
      nr = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         if (rdy_o[1]) nr++;
         chk("L0 busy pattern", 32'(busy_o[1]), 32'(n % 2));
         if (rdy_o[1]) chk("L0 stream data", dout_o[1], 32'hCAFE_F00D);
      end
      req_i[1] = 1'b0; addr_i[1] = '0;
      chk("L0 ready count", 32'(nr), 32'd6);

      xfer(0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, cyc, d, e);
      xfer(0, 1'b0, 32'h20, 32'd0, 1'b0, cyc, d, e);
      @(negedge clock);
      req_i[0] = 1'b1; mw_i[0] = 1'b1; addr_i[0] = 32'h20; din_i[0] = 32'hFFFF_FFFF;
      @(negedge clock);
      chk("busy in wait", 32'(busy_o[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort busy", 32'(busy_o[0]), 32'd0);
      chk("abort ready", 32'(rdy_o[0]), 32'd0);
      chk("abort data_out", dout_o[0], 32'd0);
      req_i[0] = 1'b0; mw_i[0] = 1'b0; addr_i[0] = '0; din_i[0] = '0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      xfer(0, 1'b0, 32'h20, 32'd0, 1'b0, cyc, d, e);
      chk("store discarded", d, 32'h1234_5678);

      for (int k = 0; k < 2; k++) begin
         xfer(k, 1'b1, 32'h14, 32'h600D_F00D, 1'b1, cyc, d, e);
         xfer(k, 1'b0, 32'h14, 32'd0, 1'b1, cyc, d, e);
         chk("latched fields", d, 32'h600D_F00D);
      end

      for (int t = 0; t < 160; t++) begin
         int          r;
         int          idx;
         logic [31:0] a;
         r   = int'($urandom_range(0, 99));
         idx = int'($urandom_range(0, 15));
         if (r < 70)      a = 32'(idx * 4);
         else if (r < 85) a = 32'(idx * 4) + $urandom_range(1, 3);
         else             a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
         xfer(t % 2, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0),
              cyc, d, e);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      repeat (4) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
